// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer that raises a CPU interrupt on expiry.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only), ACK (pending flag).
module timer_irq_dev #(
   parameter int CNT_W   = 32,
   parameter int ADDR_LO = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_e;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_ACK    = 2'd3;

   localparam logic [1:0] MODE_RELOAD = 2'd1;

   state_e           state_q, state_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pending_q, pending_d;

   logic [1:0]  off;
   logic        wr_en;
   logic [31:0] preset_merged;
   logic        unused_addr;

   assign off         = addr[ADDR_LO+1:ADDR_LO];
   assign wr_en       = sel & (|byteen);
   assign unused_addr = ^addr;

   always_comb begin
      preset_merged = 32'(preset_q);
      for (int b = 0; b < 4; b++) begin
         if (byteen[b]) preset_merged[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      preset_d  = preset_q;
      count_d   = count_q;
      pending_d = pending_q;

      if (wr_en) begin
         case (off)
            OFF_CTRL:   if (byteen[0]) ctrl_d = wdata[3:0];
            OFF_PRESET: preset_d = preset_merged[CNT_W-1:0];
            OFF_ACK:    pending_d = 1'b0;
            default:    ;
         endcase
      end

      // FSM decisions use *_q so a bus write only affects them from the next cycle;
      // the FSM assignments come last so the hardware set/clear wins over the bus.
      case (state_q)
         IDLE: begin
            if (ctrl_q[0]) state_d = LOAD;
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!ctrl_q[0]) begin
               state_d = IDLE;
            end else if (count_q > CNT_W'(1)) begin
               count_d = count_q - CNT_W'(1);
            end else begin
               count_d = '0;
               state_d = INT;
            end
         end
         INT: begin
            pending_d = 1'b1;
            if (ctrl_q[2:1] == MODE_RELOAD) begin
               state_d = LOAD;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is synchronous and active-low; every state register is cleared, including COUNT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         preset_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         OFF_CTRL:   rdata = {28'b0, ctrl_q};
         OFF_PRESET: rdata = 32'(preset_q);
         OFF_COUNT:  rdata = 32'(count_q);
         OFF_ACK:    rdata = {31'b0, pending_q};
         default:    rdata = '0;
      endcase
   end

   assign irq = pending_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_irq_dev.sv
// Scoreboard bench for timer_irq_dev: stimulus queues expectations, a negedge monitor checks them.
module tb_timer_irq_dev;

   logic        clk;
   logic        reset;
   logic        sel;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   timer_irq_dev #(.CNT_W(32), .ADDR_LO(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .sel    (sel),
      .addr   (addr),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   typedef struct {
      string       name;
      bit          is_irq;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   exp_t item;
   logic chk_valid;
   logic [31:0] act;
   int   n_checks = 0;
   int   n_pass   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
   task automatic drive(input bit rst_v, input bit s, input logic [1:0] off,
                        input logic [3:0] be, input logic [31:0] d);
      @(posedge clk);
      #1;
      reset     = rst_v;
      sel       = s;
      addr      = {28'b0, off, 2'b00};
      byteen    = be;
      wdata     = d;
      chk_valid = 1'b0;
   endtask

   task automatic wr(input logic [1:0] off, input logic [3:0] be, input logic [31:0] d);
      drive(1'b1, 1'b1, off, be, d);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
   endtask

   task automatic rd(input logic [1:0] off, input logic [31:0] e, input string nm);
      drive(1'b1, 1'b1, off, 4'h0, 32'h0);
      sb_q.push_back('{name: nm, is_irq: 1'b0, exp: e});
      chk_valid = 1'b1;
   endtask

   task automatic chk_irq(input logic e, input string nm);
      drive(1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
      sb_q.push_back('{name: nm, is_irq: 1'b1, exp: {31'b0, e}});
      chk_valid = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_valid) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL scoreboard: check presented with no expectation queued");
         end else begin
            item = sb_q.pop_front();
            act  = item.is_irq ? {31'b0, irq} : rdata;
            if (act === item.exp) n_pass++;
            else $display("FAIL %s: got %h, expected %h", item.name, act, item.exp);
         end
      end
   end

   initial begin
      reset = 1'b0; sel = 1'b0; addr = '0; byteen = '0; wdata = '0; chk_valid = 1'b0;

      // Reset with a full write attempt on CTRL
      repeat (3) drive(1'b0, 1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF);
      rd(2'd0, 32'h0, "rst_ctrl");
      rd(2'd1, 32'h0, "rst_preset");
      rd(2'd2, 32'h0, "rst_count");
      rd(2'd3, 32'h0, "rst_pending");
      chk_irq(1'b0, "rst_irq");

      // One-shot, PRESET=3
      wr(2'd1, 4'hF, 32'd3);
      wr(2'd0, 4'hF, 32'h9);
      chk_irq(1'b0, "os_irq_low");
      rd(2'd0, 32'h9, "os_ctrl_on");
      rd(2'd2, 32'd3, "os_count3");
      rd(2'd2, 32'd2, "os_count2");
      rd(2'd2, 32'd1, "os_count1");
      rd(2'd2, 32'd0, "os_count0");
      chk_irq(1'b1, "os_irq_high");
      rd(2'd0, 32'h8, "os_ctrl_en_clr");
      wr(2'd3, 4'hF, 32'h0);
      chk_irq(1'b0, "os_irq_acked");
      rd(2'd3, 32'h0, "os_pending_acked");

      // Auto-reload, PRESET=2
      wr(2'd1, 4'hF, 32'd2);
      wr(2'd0, 4'hF, 32'hB);
      idle(2);
      rd(2'd2, 32'd2, "ar_count2");
      rd(2'd2, 32'd1, "ar_count1");
      rd(2'd3, 32'h0, "ar_int_not_yet");
      rd(2'd3, 32'h1, "ar_pending1");
      wr(2'd3, 4'hF, 32'h0);
      rd(2'd3, 32'h0, "ar_ack_clears");
      wr(2'd3, 4'hF, 32'h0);
      rd(2'd3, 32'h1, "ar_ack_in_int_set_wins");
      chk_irq(1'b1, "ar_irq");
      wr(2'd3, 4'hF, 32'h0);
      rd(2'd3, 32'h0, "ar_ack_again");
      rd(2'd3, 32'h1, "ar_period4");
      wr(2'd0, 4'hF, 32'h0);
      wr(2'd3, 4'hF, 32'h0);
      rd(2'd2, 32'd1, "ar_stop_count_held");
      rd(2'd3, 32'h0, "ar_stop_no_pending");

      // Byte enables and read-only COUNT
      wr(2'd1, 4'hF, 32'h0);
      wr(2'd1, 4'b0101, 32'hAABB_CCDD);
      rd(2'd1, 32'h00BB_00DD, "be_preset");
      wr(2'd2, 4'hF, 32'h1234_5678);
      rd(2'd2, 32'd1, "count_read_only");
      wr(2'd0, 4'b1110, 32'hFFFF_FFFF);
      rd(2'd0, 32'h0, "be_ctrl_upper_only");
      wr(2'd0, 4'b0001, 32'hFFFF_FFF6);
      rd(2'd0, 32'h6, "ctrl_mode3_readback");
      wr(2'd0, 4'hF, 32'h0);

      // CTRL write during the INT cycle, one-shot
      wr(2'd1, 4'hF, 32'd1);
      wr(2'd0, 4'hF, 32'h9);
      idle(3);
      wr(2'd0, 4'hF, 32'hF);
      rd(2'd0, 32'hE, "int_cycle_ctrl_write");
      rd(2'd3, 32'h1, "int_cycle_pending");
      chk_irq(1'b1, "int_cycle_irq");
      wr(2'd3, 4'hF, 32'h0);
      wr(2'd0, 4'hF, 32'h0);

      // Interrupt mask
      wr(2'd0, 4'hF, 32'h1);
      idle(4);
      rd(2'd3, 32'h1, "mask_pending");
      chk_irq(1'b0, "mask_irq_low");
      wr(2'd0, 4'hF, 32'h8);
      chk_irq(1'b1, "unmask_irq_high");
      wr(2'd0, 4'hF, 32'h0);
      chk_irq(1'b0, "remask_irq_low");
      rd(2'd3, 32'h1, "remask_pending_kept");
      wr(2'd3, 4'hF, 32'h0);

      // Abort mid-count, PRESET rewritten during CNT
      wr(2'd1, 4'hF, 32'd10);
      wr(2'd0, 4'hF, 32'h9);
      idle(2);
      rd(2'd2, 32'd10, "abort_count10");
      wr(2'd1, 4'hF, 32'd3);
      rd(2'd2, 32'd8, "preset_wr_no_effect");
      rd(2'd2, 32'd7, "abort_count7");
      wr(2'd0, 4'hF, 32'h8);
      rd(2'd2, 32'd5, "abort_count5_a");
      rd(2'd2, 32'd5, "abort_count5_b");
      rd(2'd2, 32'd5, "abort_count5_c");
      rd(2'd3, 32'h0, "abort_no_pending");
      chk_irq(1'b0, "abort_no_irq");
      rd(2'd1, 32'd3, "preset_new_value");

      // Next LOAD uses the new PRESET
      wr(2'd0, 4'hF, 32'h9);
      idle(2);
      rd(2'd2, 32'd3, "reload_new_preset");
      idle(4);
      rd(2'd3, 32'h1, "reload_pending");

      // Reset mid-count with pending set
      wr(2'd1, 4'hF, 32'd9);
      wr(2'd0, 4'hF, 32'h9);
      idle(2);
      rd(2'd2, 32'd9, "mid_count9");
      chk_irq(1'b1, "mid_irq_before_reset");
      rd(2'd2, 32'd7, "mid_count7");
      drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
      rd(2'd2, 32'h0, "mid_rst_count");
      rd(2'd3, 32'h0, "mid_rst_pending");
      chk_irq(1'b0, "mid_rst_irq");
      rd(2'd0, 32'h0, "mid_rst_ctrl");
      rd(2'd1, 32'h0, "mid_rst_preset");

      idle(1);
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         $display("FAIL drain: %0d expectations never checked, expected 0", sb_q.size());
         n_checks += sb_q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
